// File: rtl/pll_reconfig_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_ctrl_if
//  Description : Divider-code request channel between one requester and the
//                rPLL reconfiguration sequencer (valid/ready handshake).
//                  cfg_valid : requester presents new codes
//                  cfg_ready : controller accepts codes this cycle
//                  cfg_fdiv  : requested FBDSEL code (6 bit)
//                  cfg_idiv  : requested IDSEL code (6 bit)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pll_reconfig_ctrl_if;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [5:0] cfg_fdiv;
    logic [5:0] cfg_idiv;

    modport master (output cfg_valid, output cfg_fdiv, output cfg_idiv,
                    input  cfg_ready);
    modport slave  (input  cfg_valid, input  cfg_fdiv, input  cfg_idiv,
                    output cfg_ready);
endinterface
`default_nettype wire

// File: rtl/pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pll_reconfig_ctrl
//  Description : Sequencer for an rPLL in dynamic-divider mode. Drives the PLL
//                reset and FBDSEL/IDSEL codes, supervises lock with a timeout
//                and bounded retries, and recovers from lock loss. Runs from
//                the PLL reference clock so it keeps working while unlocked.
//  Ports       : clkin        - reference clock (also the PLL CLKIN)
//                reset        - synchronous active-high reset
//                cfg          - code request channel (slave side)
//                pll_lock     - rPLL LOCK, asynchronous to clkin
//                pll_reset    - to rPLL RESET
//                pll_fdiv     - to rPLL FBDSEL (raw code)
//                pll_idiv     - to rPLL IDSEL (raw code)
//                pll_ok       - PLL locked and stable
//                fault        - lock retries exhausted
//                relock_count - saturating count of lock-loss events in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_ctrl #(
    parameter logic [5:0] DEF_FDIV     = 6'd8,
    parameter logic [5:0] DEF_IDIV     = 6'd2,
    parameter int         RST_CYCLES   = 16,
    parameter int         LOCK_STABLE  = 256,
    parameter int         LOCK_TIMEOUT = 65536,
    parameter int         MAX_RETRY    = 3,
    parameter int         CNT_W        = 17
) (
    input  wire logic          clkin,
    input  wire logic          reset,
    pll_reconfig_ctrl_if.slave cfg,
    input  wire logic          pll_lock,
    output logic               pll_reset,
    output logic [5:0]         pll_fdiv,
    output logic [5:0]         pll_idiv,
    output logic               pll_ok,
    output logic               fault,
    output logic [7:0]         relock_count
);

    localparam logic [1:0] ST_APPLY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [CNT_W-1:0] c_RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_STABLE       = CNT_W'(LOCK_STABLE);
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE      = CNT_W'(1);
    localparam logic [7:0]       c_MAX_RETRY    = 8'(MAX_RETRY);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_stable;
    logic [7:0]       r_retries;
    logic             r_lock_meta;
    logic             r_lock_s;

    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_stable_nxt;
    logic [CNT_W-1:0] w_stable_inc;
    logic [7:0]       w_retries_nxt;
    logic             w_accept;
    logic             w_load_cfg;
    logic             w_relock_inc;

    // cfg_ready is registered and only high in RUN/FAULT, so a handshake
    // can only complete in those two states.
    assign w_accept     = cfg.cfg_valid && cfg.cfg_ready;
    assign w_stable_inc = r_stable + c_CNT_ONE;

    always_comb begin
        w_next_state  = r_state;
        w_cnt_nxt     = r_cnt;
        w_stable_nxt  = r_stable;
        w_retries_nxt = r_retries;
        w_load_cfg    = 1'b0;
        w_relock_inc  = 1'b0;
        case (r_state)
            ST_APPLY: begin
                if (r_cnt == c_RST_LAST) begin
                    w_next_state = ST_WAIT;
                    w_cnt_nxt    = '0;
                    w_stable_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_WAIT: begin
                w_cnt_nxt    = r_cnt + c_CNT_ONE;
                w_stable_nxt = r_lock_s ? w_stable_inc : '0;
                // A lock that completes on the timeout cycle still counts.
                if (r_lock_s && (w_stable_inc == c_STABLE)) begin
                    w_next_state = ST_RUN;
                    w_cnt_nxt    = '0;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_retries < c_MAX_RETRY) begin
                        w_retries_nxt = r_retries + 8'd1;
                        w_next_state  = ST_APPLY;
                    end else begin
                        w_next_state = ST_FAULT;
                    end
                end
            end
            ST_RUN: begin
                // New codes take precedence over a simultaneous lock loss.
                if (w_accept) begin
                    w_load_cfg    = 1'b1;
                    w_retries_nxt = '0;
                    w_next_state  = ST_APPLY;
                    w_cnt_nxt     = '0;
                end else if (!r_lock_s) begin
                    w_relock_inc  = 1'b1;
                    w_retries_nxt = '0;
                    w_next_state  = ST_APPLY;
                    w_cnt_nxt     = '0;
                end
            end
            ST_FAULT: begin
                if (w_accept) begin
                    w_load_cfg    = 1'b1;
                    w_retries_nxt = '0;
                    w_next_state  = ST_APPLY;
                    w_cnt_nxt     = '0;
                end
            end
            default: begin
                w_next_state = ST_APPLY;
                w_cnt_nxt    = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they always line up
    // with the state the block is actually in.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state       <= ST_APPLY;
            r_cnt         <= '0;
            r_stable      <= '0;
            r_retries     <= '0;
            r_lock_meta   <= 1'b0;
            r_lock_s      <= 1'b0;
            pll_reset     <= 1'b1;
            pll_fdiv      <= DEF_FDIV;
            pll_idiv      <= DEF_IDIV;
            cfg.cfg_ready <= 1'b0;
            pll_ok        <= 1'b0;
            fault         <= 1'b0;
            relock_count  <= '0;
        end else begin
            r_state       <= w_next_state;
            r_cnt         <= w_cnt_nxt;
            r_stable      <= w_stable_nxt;
            r_retries     <= w_retries_nxt;
            r_lock_meta   <= pll_lock;
            r_lock_s      <= r_lock_meta;
            pll_reset     <= (w_next_state == ST_APPLY) || (w_next_state == ST_FAULT);
            cfg.cfg_ready <= (w_next_state == ST_RUN) || (w_next_state == ST_FAULT);
            pll_ok        <= (w_next_state == ST_RUN);
            fault         <= (w_next_state == ST_FAULT);
            // Codes only move together with the transition into APPLY,
            // i.e. while pll_reset is high.
            if (w_load_cfg) begin
                pll_fdiv <= cfg.cfg_fdiv;
                pll_idiv <= cfg.cfg_idiv;
            end
            if (w_relock_inc && (relock_count != 8'hFF)) begin
                relock_count <= relock_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pll_reconfig_ctrl
//  Description : Self-checking bench for pll_reconfig_ctrl. A lock model and
//                randomized requester drive the DUT; expected timing and
//                register values come from event-level arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_reconfig_ctrl;

    localparam int c_RST_CYCLES   = 4;
    localparam int c_LOCK_STABLE  = 8;
    localparam int c_LOCK_TIMEOUT = 64;
    localparam int c_MAX_RETRY    = 2;
    localparam int c_SYNC         = 2;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset;
    logic [5:0] pll_fdiv;
    logic [5:0] pll_idiv;
    logic       pll_ok;
    logic       fault;
    logic [7:0] relock_count;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] exp_fdiv;
    logic [5:0] exp_idiv;
    int         exp_relock;

    pll_reconfig_ctrl_if cfg_if ();

    pll_reconfig_ctrl #(
        .DEF_FDIV     (6'd8),
        .DEF_IDIV     (6'd2),
        .RST_CYCLES   (c_RST_CYCLES),
        .LOCK_STABLE  (c_LOCK_STABLE),
        .LOCK_TIMEOUT (c_LOCK_TIMEOUT),
        .MAX_RETRY    (c_MAX_RETRY),
        .CNT_W        (17)
    ) u_dut (
        .clkin        (clkin),
        .reset        (reset),
        .cfg          (cfg_if),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .pll_fdiv     (pll_fdiv),
        .pll_idiv     (pll_idiv),
        .pll_ok       (pll_ok),
        .fault        (fault),
        .relock_count (relock_count)
    );

    always #5 clkin = ~clkin;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_fdiv"}, pll_fdiv, 8);
        check({tag, "_idiv"}, pll_idiv, 2);
        check({tag, "_ok"}, pll_ok, 0);
        check({tag, "_ready"}, cfg_if.cfg_ready, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_relock"}, relock_count, 0);
    endtask

    // Called right after the cycle in which pll_reset went high.
    task automatic wait_fall(input string tag);
        int   n = -1;
        logic bad = 1'b0;
        pll_lock = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (!pll_reset) begin
                n = k;
                break;
            end
            if (cfg_if.cfg_ready || pll_ok || pll_fdiv !== exp_fdiv || pll_idiv !== exp_idiv)
                bad = 1'b1;
        end
        check({tag, "_rst_len"}, n, c_RST_CYCLES);
        check({tag, "_apply"}, bad, 0);
    endtask

    task automatic wait_rise(input string tag, input int exp);
        int n = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (pll_reset) begin
                n = k;
                break;
            end
        end
        check({tag, "_rise"}, n, exp);
    endtask

    // Called right after pll_reset fell. Lock rises after tick rise1; an
    // optional one-cycle-or-longer dropout spans ticks [low_at, rise2).
    task automatic wait_lock(input string tag, input int rise1, input int low_at, input int rise2);
        int   k_ok = -1;
        int   exp_k;
        logic bad = 1'b0;
        exp_k = ((low_at > 0) ? rise2 : rise1) + c_SYNC + c_LOCK_STABLE;
        for (int k = 1; k <= c_LOCK_TIMEOUT + 8; k++) begin
            tick();
            if (pll_ok) begin
                k_ok = k;
                break;
            end
            if (pll_reset || cfg_if.cfg_ready || pll_fdiv !== exp_fdiv || pll_idiv !== exp_idiv)
                bad = 1'b1;
            pll_lock = (k >= rise1) && !((low_at > 0) && (k >= low_at) && (k < rise2));
        end
        check({tag, "_ok_at"}, k_ok, exp_k);
        check({tag, "_wait"}, bad, 0);
        check({tag, "_ready"}, cfg_if.cfg_ready, 1);
        check({tag, "_fdiv"}, pll_fdiv, exp_fdiv);
        check({tag, "_idiv"}, pll_idiv, exp_idiv);
        check({tag, "_relock"}, relock_count, exp_relock);
    endtask

    task automatic do_cfg(input string tag, input logic [5:0] f, input logic [5:0] i);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_fdiv  = f;
        cfg_if.cfg_idiv  = i;
        tick();
        cfg_if.cfg_valid = 1'b0;
        exp_fdiv = f;
        exp_idiv = i;
        check({tag, "_pll_reset"}, pll_reset, 1);
        check({tag, "_fdiv"}, pll_fdiv, f);
        check({tag, "_idiv"}, pll_idiv, i);
        check({tag, "_ok"}, pll_ok, 0);
        check({tag, "_fault"}, fault, 0);
    endtask

    task automatic power_up(input string tag);
        reset    = 1'b1;
        pll_lock = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        exp_fdiv   = 6'd8;
        exp_idiv   = 6'd2;
        exp_relock = 0;
        check_reset_vals({tag, "_rst"});
        reset = 1'b0;
        wait_fall(tag);
    endtask

    initial begin
        int   r1;
        int   n_hold;
        logic bad;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_fdiv  = 6'd0;
        cfg_if.cfg_idiv  = 6'd0;

        // Power-up with lock 10 cycles after reset release of the PLL.
        power_up("pu");
        wait_lock("pu", 10, 0, 0);

        // Reconfiguration to 20/3.
        do_cfg("recfg", 6'd20, 6'd3);
        wait_fall("recfg");
        wait_lock("recfg", int'($urandom_range(1, 20)), 0, 0);

        // Lock glitch; requester also pushes ignored codes while not ready.
        do_cfg("glitch_cfg", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_fdiv  = ~exp_fdiv;
        cfg_if.cfg_idiv  = ~exp_idiv;
        wait_fall("glitch");
        cfg_if.cfg_valid = 1'b0;
        r1 = int'($urandom_range(1, 10));
        wait_lock("glitch", r1, r1 + 5, r1 + 6);

        // Timeout: three attempts then FAULT.
        do_cfg("tmo_cfg", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        for (int a = 0; a <= c_MAX_RETRY; a++) begin
            wait_fall($sformatf("tmo%0d", a));
            wait_rise($sformatf("tmo%0d", a), c_LOCK_TIMEOUT);
            check($sformatf("tmo%0d_fault", a), fault, (a == c_MAX_RETRY) ? 1 : 0);
            check($sformatf("tmo%0d_fdiv", a), pll_fdiv, exp_fdiv);
        end
        n_hold = int'($urandom_range(5, 20));
        bad = 1'b0;
        for (int k = 0; k < n_hold; k++) begin
            tick();
            if (!fault || !pll_reset || pll_ok || !cfg_if.cfg_ready) bad = 1'b1;
        end
        check("fault_hold", bad, 0);
        do_cfg("fault_clr", 6'd8, 6'd2);
        wait_fall("fault_clr");
        wait_lock("fault_clr", int'($urandom_range(1, 20)), 0, 0);

        // Lock loss and cfg in the same RUN cycle: cfg wins.
        pll_lock = 1'b0;
        tick();
        tick();
        check("simul_pre", pll_reset, 0);
        do_cfg("simul", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        check("simul_relock", relock_count, exp_relock);
        wait_fall("simul");
        wait_lock("simul", int'($urandom_range(1, 20)), 0, 0);

        // Repeated lock loss: counter saturates at 255.
        for (int n = 1; n <= 300; n++) begin
            pll_lock = 1'b0;
            wait_rise("loss", c_SYNC + 1);
            exp_relock = (n > 255) ? 255 : n;
            if (pll_fdiv !== exp_fdiv || pll_idiv !== exp_idiv || relock_count !== 8'(exp_relock))
                check($sformatf("loss%0d_state", n), {relock_count, 2'b0, pll_fdiv, 2'b0, pll_idiv},
                      {8'(exp_relock), 2'b0, exp_fdiv, 2'b0, exp_idiv});
            else
                check($sformatf("loss%0d_relock", n), relock_count, exp_relock);
            wait_fall("loss");
            wait_lock("loss", int'($urandom_range(1, 4)), 0, 0);
        end
        check("loss_sat", relock_count, 255);

        // Reset in the middle of WAIT_LOCK.
        do_cfg("midrst_cfg", 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        wait_fall("midrst");
        pll_lock = 1'b1;
        for (int k = 0; k < int'($urandom_range(3, 10)); k++) tick();
        reset = 1'b1;
        tick();
        check_reset_vals("midrst");
        reset = 1'b0;
        exp_fdiv   = 6'd8;
        exp_idiv   = 6'd2;
        exp_relock = 0;
        wait_fall("repu");
        wait_lock("repu", int'($urandom_range(1, 20)), 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
